memory_access: RTL and testbench
================================

// Module: memory_access
// PURPOSE
//  MEM stage of the 5-stage pipeline; sits directly downstream of the EXECUTION stage and consumes its XM_*/DX_* outputs.
//  Performs word loads/stores against an internal data memory and resolves beq/bne/bgt from the EX flags.
//  Registers the write-back result into the MW pipeline register and squashes in-flight shadow slots after a taken branch.
// PARAMETERS
//  MEM_DEPTH     256  data memory depth in 32-bit words (power of 2)
//  ADDR_W        8    word-address width, log2(MEM_DEPTH)
//  SQUASH_SLOTS  2    shadow instructions already past ID that are bubbled after a taken branch
// PORTS
//  clk            in   1   clock, all state on posedge
//  rst            in   1   asynchronous, active-high reset
//  ALUout         in   32  EX result / byte address for lw/sw
//  XM_RD          in   5   destination register (0 = no write-back)
//  XM_MemToReg    in   1   1 = load: write-back data comes from memory
//  XM_RT          in   32  store data
//  XM_MemWrite    in   1   1 = store
//  DX_PC          in   32  PC of the branch instruction as forwarded by EX
//  DX_offset      in   32  sign-extended branch word offset
//  zero           in   1   EX flag: A==B
//  sign           in   1   EX flag: A>B
//  DX_beq         in   1   branch-if-equal
//  DX_bgt         in   1   branch-if-greater
//  DX_bne         in   1   branch-if-not-equal
//  MW_WBdata      out  32  write-back data
//  MW_RD          out  5   write-back destination register
//  branch_taken   out  1   one-cycle pulse: redirect fetch, flush IF/ID
//  branch_target  out  32  redirect PC, valid while branch_taken=1
// BEHAVIOUR
//  - Reset: MW_WBdata=0, MW_RD=0, branch_taken=0, branch_target=0, squash_cnt=0. Memory array is not reset; contents persist.
//  - Word address waddr = ALUout[ADDR_W+1:2]. ALUout[1:0] is ignored (no alignment trap). Upper bits are ignored, so addresses wrap modulo MEM_DEPTH.
//  - Latency is 1 cycle: inputs at edge N appear on the outputs after edge N.
//  - live = (squash_cnt==0). All of the following happen on posedge:
//  - Store: if live & XM_MemWrite, then mem[waddr] <= XM_RT.
//  - Load/ALU: MW_WBdata <= XM_MemToReg ? mem[waddr] : ALUout. A load and store to the same address in the same cycle returns the old data (read-before-write).
//  - MW_RD <= (!live | XM_MemWrite) ? 0 : XM_RD. Stores and bubbles never write back. MW_WBdata still updates when !live, but is don't-care.
//  - Branch condition: take = live & ((DX_beq&zero) | (DX_bne&~zero) | (DX_bgt&sign)). Multiple flags are ORed.
//  - branch_taken <= take.
//  - branch_target <= take ? DX_PC + (DX_offset<<2) : branch_target. Addition is 32-bit and wraps silently.
//  - Squash counter (0..SQUASH_SLOTS):
//    - take: load SQUASH_SLOTS.
//    - else if squash_cnt!=0: decrement.
//    - else: hold.
//    - A branch arriving while squash_cnt!=0 is itself a bubble and cannot retrigger.
//  - branch_taken is high for exactly one cycle per taken branch. Back-to-back taken pulses are impossible for SQUASH_SLOTS>=1.
//  - Reset mid-squash clears squash_cnt. The first instruction after reset release is live.
// TESTING
//  1. Store then load: sw ALUout=0x10, XM_RT=0xDEADBEEF; next cycle lw ALUout=0x10, XM_RD=7 -> MW_WBdata=0xDEADBEEF, MW_RD=7. For the sw cycle, MW_RD=0.
//  2. ALU passthrough: MemToReg=0, ALUout=0x1234, XM_RD=5 -> one edge later MW_WBdata=0x1234, MW_RD=5.
//  3. Branch conditions:
//     - DX_beq=1, zero=1, DX_PC=0x40, offset=3 -> branch_taken=1 for one cycle, branch_target=0x4C.
//     - DX_bne=1, zero=1 -> branch_taken=0.
//     - DX_bgt=1, sign=1 -> taken.
//  4. Squash: taken beq, then sw 0x20<=0x1111, sw 0x20<=0x2222 (both bubbled, MW_RD=0), then sw 0x20<=0x3333 -> lw 0x20 returns 0x3333.
//     A beq with zero=1 in slot 1 -> branch_taken stays 0.
//  5. Wrap/alignment: sw ALUout=0x400 data 0xA5A5A5A5 (depth 256) -> lw ALUout=0x003 returns 0xA5A5A5A5.
//  6. Reset mid-squash: rst pulse while squash_cnt=1 -> all outputs 0 asynchronously. The next sw after release is live, and memory written before reset is still readable.

Source files
------------

// File: rtl/memory_access.sv
// memory_access: MEM stage. Word loads/stores against a local data memory,
// beq/bne/bgt resolution from EX flags, MW register and post-branch squash.
//
// Ports:
//   clk, rst            clock, async active-high reset
//   ALUout              EX result / byte address for lw/sw
//   XM_RD, XM_MemToReg  write-back destination / load select
//   XM_RT, XM_MemWrite  store data / store enable
//   DX_PC, DX_offset    branch PC and sign-extended word offset
//   zero, sign          EX flags (A==B, A>B)
//   DX_beq/bgt/bne      branch kind
//   MW_WBdata, MW_RD    registered write-back data / destination
//   branch_taken        one-cycle redirect pulse
//   branch_target       redirect PC, valid while branch_taken=1
module memory_access #(
    parameter int MEM_DEPTH    = 256,
    parameter int ADDR_W       = 8,
    parameter int SQUASH_SLOTS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ALUout,
    input  logic [4:0]  XM_RD,
    input  logic        XM_MemToReg,
    input  logic [31:0] XM_RT,
    input  logic        XM_MemWrite,
    input  logic [31:0] DX_PC,
    input  logic [31:0] DX_offset,
    input  logic        zero,
    input  logic        sign,
    input  logic        DX_beq,
    input  logic        DX_bgt,
    input  logic        DX_bne,
    output logic [31:0] MW_WBdata,
    output logic [4:0]  MW_RD,
    output logic        branch_taken,
    output logic [31:0] branch_target
);

    localparam int CW = $clog2(SQUASH_SLOTS + 1);
    localparam logic [CW-1:0] SLOTS = CW'(SQUASH_SLOTS);

    logic [31:0]       mem [MEM_DEPTH];
    logic [ADDR_W-1:0] waddr;
    logic [CW-1:0]     squash_cnt;
    logic              live;
    logic              take;
    logic              unused_bits;

    // Byte offset and high address bits are dropped: no trap, wrap mod depth.
    assign waddr       = ALUout[ADDR_W+1:2];
    assign unused_bits = ^{ALUout[31:ADDR_W+2], ALUout[1:0]};

    assign live = (squash_cnt == '0);
    assign take = live & ((DX_beq & zero) | (DX_bne & ~zero) | (DX_bgt & sign));

    // Array is intentionally not reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (live && XM_MemWrite)
            mem[waddr] <= XM_RT;
    end

    // Read of mem here sees pre-edge contents, giving read-before-write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            MW_WBdata <= '0;
            MW_RD     <= '0;
        end else begin
            MW_WBdata <= XM_MemToReg ? mem[waddr] : ALUout;
            MW_RD     <= (!live || XM_MemWrite) ? 5'd0 : XM_RD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_taken  <= 1'b0;
            branch_target <= '0;
        end else begin
            branch_taken <= take;
            if (take)
                branch_target <= DX_PC + (DX_offset << 2);
        end
    end

    // A branch seen while counting is a shadow bubble, so take is already 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            squash_cnt <= '0;
        else if (take)
            squash_cnt <= SLOTS;
        else if (squash_cnt != '0)
            squash_cnt <= squash_cnt - 1'b1;
    end

endmodule

// File: tb/tb_memory_access.sv
// tb_memory_access: table-driven directed check of memory_access plus a
// hand-written reset-during-squash sequence.
module tb_memory_access;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ALUout;
    logic [4:0]  XM_RD;
    logic        XM_MemToReg;
    logic [31:0] XM_RT;
    logic        XM_MemWrite;
    logic [31:0] DX_PC;
    logic [31:0] DX_offset;
    logic        zero;
    logic        sign;
    logic        DX_beq;
    logic        DX_bgt;
    logic        DX_bne;
    logic [31:0] MW_WBdata;
    logic [4:0]  MW_RD;
    logic        branch_taken;
    logic [31:0] branch_target;

    int n_cmp = 0;
    int n_bad = 0;

    memory_access dut (
        .clk(clk), .rst(rst),
        .ALUout(ALUout), .XM_RD(XM_RD), .XM_MemToReg(XM_MemToReg),
        .XM_RT(XM_RT), .XM_MemWrite(XM_MemWrite),
        .DX_PC(DX_PC), .DX_offset(DX_offset),
        .zero(zero), .sign(sign),
        .DX_beq(DX_beq), .DX_bgt(DX_bgt), .DX_bne(DX_bne),
        .MW_WBdata(MW_WBdata), .MW_RD(MW_RD),
        .branch_taken(branch_taken), .branch_target(branch_target)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] alu;
        logic [4:0]  rd;
        logic        mtr;
        logic [31:0] rt;
        logic        mw;
        logic [31:0] pc;
        logic [31:0] off;
        logic        z, s, beq, bgt, bne;
        logic        chk_wb;
        logic [31:0] e_wb;
        logic [4:0]  e_rd;
        logic        e_bt;
        logic [31:0] e_tgt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [31:0] alu, input logic [4:0] rd,
                       input logic mtr, input logic [31:0] rt, input logic mw,
                       input logic [31:0] pc, input logic [31:0] off,
                       input logic z, input logic s, input logic beq,
                       input logic bgt, input logic bne, input logic chk_wb,
                       input logic [31:0] e_wb, input logic [4:0] e_rd,
                       input logic e_bt, input logic [31:0] e_tgt);
        vec_t v;
        v.alu = alu; v.rd = rd; v.mtr = mtr; v.rt = rt; v.mw = mw;
        v.pc = pc; v.off = off; v.z = z; v.s = s;
        v.beq = beq; v.bgt = bgt; v.bne = bne; v.chk_wb = chk_wb;
        v.e_wb = e_wb; v.e_rd = e_rd; v.e_bt = e_bt; v.e_tgt = e_tgt;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        ALUout = v.alu; XM_RD = v.rd; XM_MemToReg = v.mtr;
        XM_RT = v.rt; XM_MemWrite = v.mw;
        DX_PC = v.pc; DX_offset = v.off; zero = v.z; sign = v.s;
        DX_beq = v.beq; DX_bgt = v.bgt; DX_bne = v.bne;
    endtask

    task automatic step(input vec_t v, input string tag);
        @(negedge clk);
        drive(v);
        @(posedge clk);
        #1;
        if (v.chk_wb)
            chk({tag, ".wb"}, MW_WBdata, v.e_wb);
        chk({tag, ".rd"}, {27'd0, MW_RD}, {27'd0, v.e_rd});
        chk({tag, ".bt"}, {31'd0, branch_taken}, {31'd0, v.e_bt});
        chk({tag, ".tgt"}, branch_target, v.e_tgt);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".wb"}, MW_WBdata, 32'd0);
        chk({tag, ".rd"}, {27'd0, MW_RD}, 32'd0);
        chk({tag, ".bt"}, {31'd0, branch_taken}, 32'd0);
        chk({tag, ".tgt"}, branch_target, 32'd0);
    endtask

    vec_t h;

    initial begin
        //  alu          rd mtr rt          mw pc           off          z s beq bgt bne chk e_wb         e_rd bt tgt
        add(32'h10,      3, 0, 32'hDEADBEEF, 1, 0,          0,           0,0,0,0,0, 1, 32'h10,      0, 0, 32'h0);
        add(32'h10,      7, 1, 0,           0, 0,          0,           0,0,0,0,0, 1, 32'hDEADBEEF,7, 0, 32'h0);
        add(32'h1234,    5, 0, 0,           0, 0,          0,           0,0,0,0,0, 1, 32'h1234,    5, 0, 32'h0);
        add(32'h55,      1, 0, 0,           0, 32'h40,     3,           1,0,0,0,1, 1, 32'h55,      1, 0, 32'h0);
        add(32'h0,       0, 0, 0,           0, 32'h40,     3,           1,0,1,0,0, 1, 32'h0,       0, 1, 32'h4C);
        add(32'h20,      2, 0, 32'h1111,    1, 32'h80,     1,           1,0,1,0,0, 0, 32'h0,       0, 0, 32'h4C);
        add(32'h20,      2, 0, 32'h2222,    1, 0,          0,           0,0,0,0,0, 0, 32'h0,       0, 0, 32'h4C);
        add(32'h20,      2, 0, 32'h3333,    1, 0,          0,           0,0,0,0,0, 0, 32'h0,       0, 0, 32'h4C);
        add(32'h20,      9, 1, 0,           0, 0,          0,           0,0,0,0,0, 1, 32'h3333,    9, 0, 32'h4C);
        add(32'h77,      2, 0, 0,           0, 32'h100,    32'hFFFFFFFF,0,1,0,1,0, 1, 32'h77,      2, 1, 32'hFC);
        add(32'h88,      4, 0, 0,           0, 0,          0,           0,0,0,0,0, 0, 32'h0,       0, 0, 32'hFC);
        add(32'h99,      4, 0, 0,           0, 0,          0,           0,0,0,0,0, 0, 32'h0,       0, 0, 32'hFC);
        add(32'h400,     0, 0, 32'hA5A5A5A5,1, 0,          0,           0,0,0,0,0, 0, 32'h0,       0, 0, 32'hFC);
        add(32'h003,     6, 1, 0,           0, 0,          0,           0,0,0,0,0, 1, 32'hA5A5A5A5,6, 0, 32'hFC);
        add(32'h0,       0, 0, 0,           0, 32'hFFFFFFF0,8,          0,0,0,0,1, 1, 32'h0,       0, 1, 32'h10);
        add(32'h0,       0, 0, 0,           0, 0,          0,           0,0,0,0,0, 0, 32'h0,       0, 0, 32'h10);
        add(32'h0,       0, 0, 0,           0, 0,          0,           0,0,0,0,0, 0, 32'h0,       0, 0, 32'h10);
        add(32'h10,      1, 1, 0,           0, 0,          0,           0,0,0,0,0, 1, 32'hDEADBEEF,1, 0, 32'h10);

        h = vecs[2];
        h.rd = 0; h.alu = 0;
        drive(h);
        rst = 1'b1;
        #2;
        chk_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++)
            step(vecs[i], $sformatf("v%0d", i));

        h = vecs[4];
        h.off = 1; h.pc = 0; h.e_tgt = 32'h4;
        step(h, "rq.br");
        h = vecs[2];
        h.alu = 32'hABC; h.e_rd = 0; h.chk_wb = 1; h.e_wb = 32'hABC;
        h.e_tgt = 32'h4;
        step(h, "rq.slot1");
        #2;
        rst = 1'b1;
        #1;
        chk_zero("rq.rst");
        @(negedge clk);
        rst = 1'b0;

        h = vecs[7];
        h.alu = 32'h30; h.rt = 32'h5555; h.e_tgt = 32'h0;
        step(h, "rq.sw");
        h = vecs[8];
        h.alu = 32'h30; h.rd = 8; h.e_wb = 32'h5555; h.e_rd = 8;
        h.e_tgt = 32'h0;
        step(h, "rq.lw");
        h = vecs[1];
        h.rd = 11; h.e_rd = 11;
        step(h, "rq.persist");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
